// File: rtl/orgate_pkg.sv
// ----------------------------------------------------------------------------
// orgate_pkg
// Shared definitions for the orgate_sticky_nin block:
//   CNT_W           width of the optional saturating event counter
//   capture_mode_e  capture mode (LEVEL or EDGE) selected by EDGE_MODE
//   idx_w(n)        index width for n channels, never narrower than 1 bit
// ----------------------------------------------------------------------------
package orgate_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } capture_mode_e;

    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/orgate_sticky_nin_if.sv
// ----------------------------------------------------------------------------
// orgate_sticky_nin_if
// Bundles the channel bus of orgate_sticky_nin.
//   in_vec, en_mask, clr_mask  driven by the master (control logic / bench)
//   pend_vec, output1,
//   first_idx, evt_cnt         driven by the slave (the aggregator)
// evt_cnt exists only when ORGATE_EVT_CNT_EN is defined.
// ----------------------------------------------------------------------------
interface orgate_sticky_nin_if
    import orgate_pkg::*;
#(
    parameter int NUM_IN = 4
) ();

    localparam int IDX_W = idx_w(NUM_IN);

    logic [NUM_IN-1:0] in_vec;
    logic [NUM_IN-1:0] en_mask;
    logic [NUM_IN-1:0] clr_mask;
    logic [NUM_IN-1:0] pend_vec;
    logic              output1;
    logic [IDX_W-1:0]  first_idx;
`ifdef ORGATE_EVT_CNT_EN
    logic [CNT_W-1:0]  evt_cnt;
`endif

    modport master (
        output in_vec,
        output en_mask,
        output clr_mask,
        input  pend_vec,
        input  output1,
`ifdef ORGATE_EVT_CNT_EN
        input  evt_cnt,
`endif
        input  first_idx
    );

    modport slave (
        input  in_vec,
        input  en_mask,
        input  clr_mask,
        output pend_vec,
        output output1,
`ifdef ORGATE_EVT_CNT_EN
        output evt_cnt,
`endif
        output first_idx
    );

endinterface

// File: rtl/orgate_sticky_nin_prio_enc.sv
// ----------------------------------------------------------------------------
// prio_enc_lsb
// Combinational lowest-set-bit encoder.
//   vec  in   WIDTH  bits to search
//   idx  out  IW     index of the lowest set bit, 0 when vec is all zero
//   any  out  1      OR of vec
// ----------------------------------------------------------------------------
module prio_enc_lsb
    import orgate_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
        any = |vec;
    end

endmodule

// File: rtl/orgate_sticky_nin.sv
// ----------------------------------------------------------------------------
// orgate_sticky_nin
// N-channel registered OR aggregator with per-channel enable mask, sticky
// pending latches, per-channel clear and level or rising-edge capture.
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   bus       orgate_sticky_nin_if.slave:
//               in_vec / en_mask / clr_mask in,
//               pend_vec / output1 / first_idx (/ evt_cnt) out
// Optional feature: define ORGATE_EVT_CNT_EN to add a 16-bit saturating
// counter of cycles in which any channel produced a new hit.
// ----------------------------------------------------------------------------
module orgate_sticky_nin
    import orgate_pkg::*;
#(
    parameter int            NUM_IN    = 4,
    parameter int            STICKY    = 1,
    parameter capture_mode_e EDGE_MODE = LEVEL
) (
    input logic              clk,
    input logic              rst,
    orgate_sticky_nin_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_IN);

    logic [NUM_IN-1:0] in_q;
    logic [NUM_IN-1:0] hit;
    logic [NUM_IN-1:0] pend_q;
    logic [NUM_IN-1:0] pend_d;
    logic [IDX_W-1:0]  enc_idx;
    logic              enc_any;

    // Edge mode compares against last cycle's inputs; in_q resets to zero so
    // an input already high right after reset counts as a rising edge.
    always_comb begin
        if (EDGE_MODE == EDGE) begin
            hit = bus.in_vec & ~in_q & bus.en_mask;
        end else begin
            hit = bus.in_vec & bus.en_mask;
        end
    end

    // In sticky mode a new hit overrides a clear of the same bit so no event
    // is lost; the enable mask gates capture only, never pending state.
    always_comb begin
        if (STICKY != 0) begin
            pend_d = (pend_q & ~bus.clr_mask) | hit;
        end else begin
            pend_d = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= '0;
            pend_q <= '0;
        end else begin
            in_q   <= bus.in_vec;
            pend_q <= pend_d;
        end
    end

`ifdef ORGATE_EVT_CNT_EN
    logic [CNT_W-1:0] evt_cnt_q;

    // Counts cycles with any new hit, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt_q <= '0;
        end else if ((|hit) && (evt_cnt_q != {CNT_W{1'b1}})) begin
            evt_cnt_q <= evt_cnt_q + 1'b1;
        end
    end

    assign bus.evt_cnt = evt_cnt_q;
`endif

    prio_enc_lsb #(
        .WIDTH (NUM_IN)
    ) u_prio_enc (
        .vec (pend_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign bus.pend_vec  = pend_q;
    assign bus.output1   = enc_any;
    assign bus.first_idx = enc_idx;

endmodule

// File: tb/tb_orgate_sticky_nin.sv
// ----------------------------------------------------------------------------
// tb_orgate_sticky_nin
// Directed bench for orgate_sticky_nin with three instances:
//   dut_a  NUM_IN=4, sticky, level capture
//   dut_b  NUM_IN=4, non-sticky, edge capture
//   dut_c  NUM_IN=8, sticky, level capture
// Define ORGATE_EVT_CNT_EN to also exercise the event counter.
// ----------------------------------------------------------------------------
module tb_orgate_sticky_nin;
    import orgate_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    orgate_sticky_nin_if #(.NUM_IN(4)) bus_a ();
    orgate_sticky_nin_if #(.NUM_IN(4)) bus_b ();
    orgate_sticky_nin_if #(.NUM_IN(8)) bus_c ();

    orgate_sticky_nin #(.NUM_IN(4), .STICKY(1), .EDGE_MODE(LEVEL)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    orgate_sticky_nin #(.NUM_IN(4), .STICKY(0), .EDGE_MODE(EDGE)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    orgate_sticky_nin #(.NUM_IN(8), .STICKY(1), .EDGE_MODE(LEVEL)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it before sampling.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Reset held two cycles with all inputs high on dut_a.
        rst = 1'b1;
        bus_a.in_vec = 4'hF; bus_a.en_mask = 4'hF; bus_a.clr_mask = 4'h0;
        bus_b.in_vec = 4'h0; bus_b.en_mask = 4'hF; bus_b.clr_mask = 4'h0;
        bus_c.in_vec = 8'h00; bus_c.en_mask = 8'hFF; bus_c.clr_mask = 8'h00;
        apply_stimulus();
        apply_stimulus();
        check_output("a_rst_pend", 32'(bus_a.pend_vec), 32'h0);
        check_output("a_rst_or", 32'(bus_a.output1), 32'h0);
        check_output("a_rst_idx", 32'(bus_a.first_idx), 32'h0);
        check_output("b_rst_pend", 32'(bus_b.pend_vec), 32'h0);
`ifdef ORGATE_EVT_CNT_EN
        check_output("a_rst_cnt", 32'(bus_a.evt_cnt), 32'h0);
`endif

        // Release: all channels captured one cycle later.
        rst = 1'b0;
        apply_stimulus();
        check_output("a_rel_pend", 32'(bus_a.pend_vec), 32'hF);
        check_output("a_rel_or", 32'(bus_a.output1), 32'h1);
        check_output("a_rel_idx", 32'(bus_a.first_idx), 32'h0);
        check_output("b_idle_pend", 32'(bus_b.pend_vec), 32'h0);

        // Clear everything on dut_a; dut_b sees channel 1 rise.
        bus_a.in_vec = 4'h0; bus_a.clr_mask = 4'hF;
        bus_b.in_vec = 4'b0010;
        apply_stimulus();
        check_output("a_clr_all", 32'(bus_a.pend_vec), 32'h0);
        check_output("b_edge_hit", 32'(bus_b.pend_vec), 32'h2);

        // Set channel 2; dut_b input held high.
        bus_a.in_vec = 4'b0100; bus_a.clr_mask = 4'h0;
        apply_stimulus();
        check_output("a_set2", 32'(bus_a.pend_vec), 32'h4);
        check_output("b_hold1", 32'(bus_b.pend_vec), 32'h0);

        // Set and clear of the same bit together: set wins.
        bus_a.clr_mask = 4'b0100;
        apply_stimulus();
        check_output("a_race_pend", 32'(bus_a.pend_vec), 32'h4);
        check_output("b_hold2", 32'(bus_b.pend_vec), 32'h0);

        // Clear alone drops the bit.
        bus_a.in_vec = 4'h0;
        apply_stimulus();
        check_output("a_clr_pend", 32'(bus_a.pend_vec), 32'h0);
        check_output("a_clr_or", 32'(bus_a.output1), 32'h0);
        check_output("b_hold3", 32'(bus_b.pend_vec), 32'h0);

        // Masked channel is not captured.
        bus_a.clr_mask = 4'h0; bus_a.en_mask = 4'b1011; bus_a.in_vec = 4'b0100;
        apply_stimulus();
        check_output("a_masked", 32'(bus_a.pend_vec), 32'h0);
        check_output("b_hold4", 32'(bus_b.pend_vec), 32'h0);

        // Unmask captures; dut_c gets hits on channels 6 and 3.
        bus_a.en_mask = 4'hF;
        bus_b.in_vec = 4'h0;
        bus_c.in_vec = 8'h48;
        apply_stimulus();
        check_output("a_unmask_pend", 32'(bus_a.pend_vec), 32'h4);
        check_output("a_unmask_idx", 32'(bus_a.first_idx), 32'h2);
        check_output("c_two_pend", 32'(bus_c.pend_vec), 32'h48);
        check_output("c_two_idx", 32'(bus_c.first_idx), 32'h3);
        check_output("c_two_or", 32'(bus_c.output1), 32'h1);

        // Remasking keeps the pending bit; clearing bit 3 exposes bit 6.
        bus_a.en_mask = 4'b1011;
        bus_c.in_vec = 8'h00; bus_c.clr_mask = 8'h08;
        apply_stimulus();
        check_output("a_remask_pend", 32'(bus_a.pend_vec), 32'h4);
        check_output("c_clr3_pend", 32'(bus_c.pend_vec), 32'h40);
        check_output("c_clr3_idx", 32'(bus_c.first_idx), 32'h6);
        check_output("c_clr3_or", 32'(bus_c.output1), 32'h1);

        // Mid-run reset drops pending state everywhere.
        rst = 1'b1;
        bus_a.in_vec = 4'h0; bus_a.en_mask = 4'hF;
        bus_b.in_vec = 4'b0010;
        bus_c.clr_mask = 8'h00;
        apply_stimulus();
        check_output("a_mid_rst_pend", 32'(bus_a.pend_vec), 32'h0);
        check_output("a_mid_rst_or", 32'(bus_a.output1), 32'h0);
        check_output("c_mid_rst_pend", 32'(bus_c.pend_vec), 32'h0);

        // Input already high after reset counts as a rising edge.
        rst = 1'b0;
        apply_stimulus();
        check_output("b_post_rst_edge", 32'(bus_b.pend_vec), 32'h2);
        check_output("a_post_rst_pend", 32'(bus_a.pend_vec), 32'h0);

`ifdef ORGATE_EVT_CNT_EN
        // Three hit cycles on dut_a, then long saturation run.
        bus_a.in_vec = 4'b0001;
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        check_output("a_cnt3", 32'(bus_a.evt_cnt), 32'h3);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        check_output("a_cnt_sat", 32'(bus_a.evt_cnt), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/orgate_sticky_nin.md
Name: orgate_sticky_nin

Overview:
- Parametrised successor to the team's fixed 4-input OR gate: an N-channel registered OR aggregator with per-channel enable mask, sticky pending latches, software clear, and level or rising-edge capture.
- Feeds status/interrupt-style "any channel active" flags into control logic.
- Also reports the lowest-index pending channel.

Parameters:
- NUM_IN, 4, number of input channels (>=2).
- STICKY, 1, 1 = pending bits latch until cleared; 0 = pending bits follow captured hits each cycle.
- EDGE_MODE, 0, 0 = level capture; 1 = rising-edge capture.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vec  in  NUM_IN  channel inputs, synchronous to clk.
- en_mask  in  NUM_IN  per-channel capture enable (1 = enabled).
- clr_mask  in  NUM_IN  per-channel clear strobe for pending bits (used when STICKY=1).
- pend_vec  out  NUM_IN  registered pending bits.
- output1  out  1  OR of pend_vec.
- first_idx  out  IDX_W  index of lowest set pend_vec bit; 0 when none set.
- evt_cnt  out  CNT_W  saturating event counter (only with ORGATE_EVT_CNT_EN).

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled at a clk edge with rst=1:
  - pend_vec=0, in_q=0, output1=0, first_idx=0, evt_cnt=0.
  - rst has priority over all other inputs.
- in_q: internal register, in_q <= in_vec every cycle.
- hit = (EDGE_MODE ? in_vec & ~in_q : in_vec) & en_mask. Combinational from the current inputs and in_q.
- STICKY=1: pend_vec <= (pend_vec & ~clr_mask) | hit.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays 1, so no event is lost.
- STICKY=0: pend_vec <= hit. clr_mask is ignored.
- Latency: a hit at edge k appears in pend_vec, output1 and first_idx immediately after edge k, i.e. 1 cycle.
- output1 = |pend_vec and first_idx = lowest set index of pend_vec. Both are combinational from flops, so glitch-free relative to clk.
- en_mask gates capture only. Deasserting a mask bit does not clear an already pending bit.
- Edge mode after reset: in_q=0, so an input already high on the first cycle after reset counts as a rising edge.
- Edge mode, input held high: exactly one hit per rising edge.
- Reset mid-operation drops all pending state. No events are remembered across reset.
- IDX_W = max(1, clog2(NUM_IN)).

Optional Feature:
- Macro: ORGATE_EVT_CNT_EN.
- Defined:
  - evt_cnt port present, width CNT_W=16.
  - Each cycle it increments by 1 if hit has any bit set, regardless of how many bits. It counts cycles with new activity.
  - Saturates at 0xFFFF with no wrap.
  - Cleared by rst only.
- Undefined: evt_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package orgate_pkg:
  - CNT_W=16.
  - Function idx_w(n) returning max(1, clog2(n)).
  - Typedef for the capture-mode enum (LEVEL, EDGE) used for EDGE_MODE.
- Sub-module prio_enc_lsb (parameter WIDTH): combinational lowest-set-bit encoder with outputs idx and any. It drives first_idx and output1.

Test Plan (NUM_IN=4 unless noted):
- Reset: hold rst=1 for 2 cycles with in_vec=4'hF.
  - During reset, pend_vec=0, output1=0, first_idx=0.
  - After release with en_mask=4'hF (level, sticky): pend_vec=4'hF, output1=1, first_idx=0 one cycle later.
- Sticky set/clear race:
  - pend_vec=4'b0100, in_vec=4'b0100, clr_mask=4'b0100 in the same cycle gives pend_vec=4'b0100.
  - Next cycle with in_vec=0, clr_mask=4'b0100 gives pend_vec=0, output1=0.
- Mask:
  - en_mask=4'b1011, in_vec=4'b0100 gives pend_vec=0.
  - Then en_mask=4'b1111 gives pend_vec=4'b0100, first_idx=2.
  - Then en_mask=4'b1011 leaves pend_vec=4'b0100.
- Edge mode (EDGE_MODE=1): in_vec[1] goes 0→1 and is held for 5 cycles with STICKY=0. pend_vec=4'b0010 for exactly one cycle, then 0.
- Priority with NUM_IN=8: hits on channels 6 and 3 give first_idx=3. Clearing bit 3 gives first_idx=6, output1 stays 1.
- ORGATE_EVT_CNT_EN:
  - 3 cycles of any hit give evt_cnt=3.
  - Forcing 70000 hit cycles leaves evt_cnt=16'hFFFF.
